link_parameter_loader: RTL and testbench
========================================

Name: link_parameter_loader

Overview:
- Upstream feeder of the per-link parameter inputs (weight_in, boundary_condition_in) of the neighbor-link array.
- Accepts a stream of per-link parameter words from the host/config FIFO over a valid/ready handshake while global_stage == STAGE_PARAMETERS_LOADING.
- Stores one word per link in registers and drives packed weight/boundary buses that stay stable, so the links latch final values on every cycle of that stage.
- Reports completion and load errors to the stage controller.

Parameters:
- NUM_LINKS, 64, number of links served; word index i maps to link i.
- MAX_WEIGHT, 2, maximum legal link weight.
- STAGE_WIDTH, 3, width of global_stage; must match the shared stage encoding.
- Derived: LINK_BIT_WIDTH = $clog2(MAX_WEIGHT+1); WORD_WIDTH = LINK_BIT_WIDTH+2; IDX_WIDTH = $clog2(NUM_LINKS+1).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- global_stage  input  STAGE_WIDTH  shared stage; uses STAGE_PARAMETERS_LOADING from the common parameter set.
- in_data  input  WORD_WIDTH  {boundary_condition[1:0], weight[LINK_BIT_WIDTH-1:0]}.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts in_data this cycle.
- weight_bus  output  NUM_LINKS*LINK_BIT_WIDTH  link i weight at [i*LINK_BIT_WIDTH +: LINK_BIT_WIDTH].
- boundary_bus  output  NUM_LINKS*2  link i boundary condition at [i*2 +: 2].
- load_done  output  1  all NUM_LINKS words received in the current loading stage.
- load_error  output  1  sticky error flag, cleared at the start of the next load.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, idx=0, all bus entries 0, in_ready=0, load_done=0, load_error=0.
- Transfer rule: a word transfers on a rising edge where in_valid && in_ready. in_ready is registered-state-derived, equal to (state==LOAD), with no combinational path from in_valid.
- FSM states IDLE, LOAD, DONE:
  - IDLE -> LOAD when global_stage==STAGE_PARAMETERS_LOADING. On entry: idx<=0, load_error<=0, load_done<=0. Bus contents are kept until overwritten.
  - LOAD: on each transfer, write entry idx and increment idx. The transfer with idx==NUM_LINKS-1 moves to DONE and sets load_done<=1 on the same edge.
  - LOAD -> IDLE if global_stage leaves STAGE_PARAMETERS_LOADING before completion. Sets load_error<=1 (incomplete load). Entries idx..NUM_LINKS-1 keep their old values.
  - DONE: in_ready=0 and load_done held. DONE -> IDLE when global_stage != STAGE_PARAMETERS_LOADING; load_done stays 1 until the next entry to LOAD.
- Bus timing: latency from accepting word i to the new value on bus entry i is 1 cycle (registered).
- Weight check: a weight > MAX_WEIGHT is stored saturated to MAX_WEIGHT and sets load_error. Boundary values 0..3 are all stored verbatim.
- Words offered while in IDLE or DONE are not accepted; in_ready stays low.
- Index arithmetic: idx is IDX_WIDTH wide, never wraps, and is never written past NUM_LINKS-1.
- Stage entry and in_valid in the same cycle: the FSM only enters LOAD on that edge, so the first transfer occurs no earlier than the following edge.
- Reset mid-LOAD: immediate return to reset values; the partially loaded buses are cleared to 0.

Optional Feature:
- Macro LINK_PARAM_CHECKSUM_EN.
- Defined: the loader adds a state CHECK between LOAD and DONE.
  - After word NUM_LINKS-1, one extra word is accepted, which must equal the XOR of all NUM_LINKS raw (unsaturated) words.
  - A mismatch sets load_error.
  - load_done asserts only after the checksum word transfers.
  - Leaving the stage while in CHECK sets load_error.
- Undefined: no CHECK state and no checksum word; load_done asserts directly after word NUM_LINKS-1.

Test Plan:
- NUM_LINKS=4, MAX_WEIGHT=2, stage set to loading, in_valid held high with words {0,1},{1,2},{2,0},{0,2} -> weight_bus=8'b10_00_10_01 and boundary_bus=8'b00_10_01_00 one cycle after the 4th transfer; load_done=1, load_error=0, in_ready=0 afterwards.
- Backpressure: in_valid toggled 1,0,1,0,... -> exactly 4 transfers; load_done rises the cycle after the 4th transfer; extra valid words in DONE are not accepted.
- Word weight=3 at index 1 (MAX_WEIGHT=2) -> entry 1 weight=2, load_error=1 and sticky through DONE, cleared on next stage entry.
- Stage leaves loading after 2 transfers -> state IDLE, load_error=1, load_done=0, entries 2..3 unchanged from the prior load.
- Assert reset mid-LOAD (asynchronous, between edges) -> buses, in_ready, load_done and load_error go to 0 immediately.
- With LINK_PARAM_CHECKSUM_EN: 4 words followed by the correct XOR -> load_done=1, load_error=0; wrong checksum -> load_done=1, load_error=1.

Source files
------------

// File: rtl/link_parameter_loader.sv
// link_parameter_loader: loads one parameter word per link during the parameter-loading stage.
// Optional checksum word after the last link word when LINK_PARAM_CHECKSUM_EN is defined.
module link_parameter_loader #(
  parameter int NUM_LINKS = 64,
  parameter int MAX_WEIGHT = 2,
  parameter int STAGE_WIDTH = 3,
  parameter logic [STAGE_WIDTH-1:0] STAGE_PARAMETERS_LOADING = STAGE_WIDTH'(1),
  localparam int LINK_BIT_WIDTH = $clog2(MAX_WEIGHT + 1),
  localparam int WORD_WIDTH = LINK_BIT_WIDTH + 2,
  localparam int IDX_WIDTH = $clog2(NUM_LINKS + 1)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [STAGE_WIDTH-1:0]             global_stage,
  input  logic [WORD_WIDTH-1:0]              in_data,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic [NUM_LINKS*LINK_BIT_WIDTH-1:0] weight_bus,
  output logic [NUM_LINKS*2-1:0]             boundary_bus,
  output logic                               load_done,
  output logic                               load_error
);
  localparam int AW = NUM_LINKS > 1 ? $clog2(NUM_LINKS) : 1;
  localparam logic [IDX_WIDTH-1:0] LAST = IDX_WIDTH'(NUM_LINKS - 1);
  localparam logic [LINK_BIT_WIDTH-1:0] MAXW = LINK_BIT_WIDTH'(MAX_WEIGHT);
`ifdef LINK_PARAM_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
`endif
  state_t r_state, w_next;
  logic [IDX_WIDTH-1:0] r_idx;
  logic [LINK_BIT_WIDTH-1:0] r_weight [NUM_LINKS];
  logic [1:0] r_boundary [NUM_LINKS];
  logic r_done, r_error;
  logic w_stage, w_xfer, w_last, w_sat;
  logic [AW-1:0] w_widx;
  logic [LINK_BIT_WIDTH-1:0] w_weight;
`ifdef LINK_PARAM_CHECKSUM_EN
  logic [WORD_WIDTH-1:0] r_xor;
  assign in_ready = r_state == LOAD || r_state == CHECK;
`else
  assign in_ready = r_state == LOAD;
`endif
  assign w_stage = global_stage == STAGE_PARAMETERS_LOADING;
  assign w_xfer = in_valid && in_ready;
  assign w_last = r_idx == LAST;
  assign w_widx = r_idx[AW-1:0];
  assign w_weight = in_data[LINK_BIT_WIDTH-1:0];
  assign w_sat = w_weight > MAXW;
  assign load_done = r_done;
  assign load_error = r_error;
  for (genvar i = 0; i < NUM_LINKS; i++) begin : g_bus
    assign weight_bus[i*LINK_BIT_WIDTH +: LINK_BIT_WIDTH] = r_weight[i];
    assign boundary_bus[i*2 +: 2] = r_boundary[i];
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = w_stage ? LOAD : IDLE;
`ifdef LINK_PARAM_CHECKSUM_EN
      LOAD: w_next = (w_xfer && w_last) ? CHECK : (w_stage ? LOAD : IDLE);
      CHECK: w_next = w_xfer ? DONE : (w_stage ? CHECK : IDLE);
`else
      LOAD: w_next = (w_xfer && w_last) ? DONE : (w_stage ? LOAD : IDLE);
`endif
      default: w_next = w_stage ? DONE : IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx <= '0;
      r_done <= 1'b0;
      r_error <= 1'b0;
      for (int k = 0; k < NUM_LINKS; k++) begin
        r_weight[k] <= '0;
        r_boundary[k] <= '0;
      end
`ifdef LINK_PARAM_CHECKSUM_EN
      r_xor <= '0;
`endif
    end else begin
      if (r_state == IDLE && w_stage) begin
        r_idx <= '0;
        r_done <= 1'b0;
        r_error <= 1'b0;
`ifdef LINK_PARAM_CHECKSUM_EN
        r_xor <= '0;
`endif
      end
      if (r_state == LOAD && w_xfer) begin
        r_weight[w_widx] <= w_sat ? MAXW : w_weight;
        r_boundary[w_widx] <= in_data[WORD_WIDTH-1 -: 2];
        r_idx <= r_idx + 1'b1;
        if (w_sat) r_error <= 1'b1;
`ifdef LINK_PARAM_CHECKSUM_EN
        r_xor <= r_xor ^ in_data;
`else
        if (w_last) r_done <= 1'b1;
`endif
      end
      // a final word arriving on the same edge the stage ends still completes the load
      if (r_state == LOAD && !w_stage && !(w_xfer && w_last)) r_error <= 1'b1;
`ifdef LINK_PARAM_CHECKSUM_EN
      if (r_state == CHECK && w_xfer) begin
        r_done <= 1'b1;
        if (in_data != r_xor) r_error <= 1'b1;
      end
      if (r_state == CHECK && !w_stage && !w_xfer) r_error <= 1'b1;
`endif
    end
  end
endmodule

// File: tb/tb_link_parameter_loader.sv
// tb_link_parameter_loader: directed checks of the link parameter loader with NUM_LINKS=4.
module tb_link_parameter_loader;
  localparam logic [2:0] LD = 3'd2;
  logic clk = 1'b0;
  logic reset;
  logic [2:0] global_stage;
  logic [3:0] in_data;
  logic in_valid;
  logic in_ready;
  logic [7:0] weight_bus;
  logic [7:0] boundary_bus;
  logic load_done;
  logic load_error;
  int passed = 0;
  int total = 0;
  link_parameter_loader #(
    .NUM_LINKS(4),
    .MAX_WEIGHT(2),
    .STAGE_WIDTH(3),
    .STAGE_PARAMETERS_LOADING(LD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .global_stage(global_stage),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .weight_bus(weight_bus),
    .boundary_bus(boundary_bus),
    .load_done(load_done),
    .load_error(load_error)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    global_stage = 3'd0;
    in_data = 4'd0;
    in_valid = 1'b0;
    step();
    step();
    total++; if (weight_bus !== 8'h00) $display("FAIL reset_weight: got %b exp 00000000", weight_bus); else passed++;
    total++; if (boundary_bus !== 8'h00) $display("FAIL reset_boundary: got %b exp 00000000", boundary_bus); else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL reset_ready: got %b exp 0", in_ready); else passed++;
    total++; if ({load_done, load_error} !== 2'b00) $display("FAIL reset_flags: got %b exp 00", {load_done, load_error}); else passed++;
    reset = 1'b0;
    step();
  endtask
  task automatic test_basic();
    global_stage = LD;
    in_valid = 1'b1;
    in_data = 4'b00_01;
    step();
    total++; if (in_ready !== 1'b1) $display("FAIL basic_ready_on_entry: got %b exp 1", in_ready); else passed++;
    step();
    in_data = 4'b01_10;
    step();
    in_data = 4'b10_00;
    step();
    in_data = 4'b00_10;
    step();
`ifdef LINK_PARAM_CHECKSUM_EN
    in_data = 4'b1101;
    step();
`endif
    total++; if (weight_bus !== 8'b10_00_10_01) $display("FAIL basic_weight: got %b exp 10001001", weight_bus); else passed++;
    total++; if (boundary_bus !== 8'b00_10_01_00) $display("FAIL basic_boundary: got %b exp 00100100", boundary_bus); else passed++;
    total++; if ({load_done, load_error} !== 2'b10) $display("FAIL basic_flags: got %b exp 10", {load_done, load_error}); else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL basic_ready_done: got %b exp 0", in_ready); else passed++;
    in_data = 4'b11_11;
    step();
    total++; if (weight_bus !== 8'b10_00_10_01) $display("FAIL basic_done_no_accept: got %b exp 10001001", weight_bus); else passed++;
  endtask
  task automatic test_backpressure();
    logic [3:0] words [4];
    words[0] = 4'b11_10;
    words[1] = 4'b00_01;
    words[2] = 4'b11_00;
    words[3] = 4'b01_01;
    global_stage = 3'd0;
    in_valid = 1'b0;
    step();
    total++; if (load_done !== 1'b1) $display("FAIL bp_done_held_idle: got %b exp 1", load_done); else passed++;
    global_stage = LD;
    step();
    total++; if (load_done !== 1'b0) $display("FAIL bp_done_cleared: got %b exp 0", load_done); else passed++;
    for (int c = 0; c < 10; c++) begin
      in_valid = c % 2 == 0;
      in_data = (c % 2 == 0 && c < 8) ? words[c/2] : 4'b11_11;
      step();
      if (c == 5) begin
        total++; if (load_done !== 1'b0) $display("FAIL bp_done_early: got %b exp 0", load_done); else passed++;
      end
      if (c == 6) begin
        total++; if (load_done !== 1'b1) $display("FAIL bp_done_rise: got %b exp 1", load_done); else passed++;
      end
    end
    in_valid = 1'b0;
    total++; if (weight_bus !== 8'b01_00_01_10) $display("FAIL bp_weight: got %b exp 01000110", weight_bus); else passed++;
    total++; if (boundary_bus !== 8'b01_11_00_11) $display("FAIL bp_boundary: got %b exp 01110011", boundary_bus); else passed++;
  endtask
  task automatic test_saturation();
    global_stage = 3'd0;
    in_valid = 1'b0;
    step();
    global_stage = LD;
    step();
    in_valid = 1'b1;
    in_data = 4'b01_00;
    step();
    total++; if (load_error !== 1'b0) $display("FAIL sat_error_before: got %b exp 0", load_error); else passed++;
    in_data = 4'b10_11;
    step();
    total++; if (load_error !== 1'b1) $display("FAIL sat_error_set: got %b exp 1", load_error); else passed++;
    in_data = 4'b11_01;
    step();
    in_data = 4'b00_00;
    step();
`ifdef LINK_PARAM_CHECKSUM_EN
    in_data = 4'b0010;
    step();
`endif
    in_valid = 1'b0;
    total++; if (weight_bus !== 8'b00_01_10_00) $display("FAIL sat_weight: got %b exp 00011000", weight_bus); else passed++;
    total++; if (boundary_bus !== 8'b00_11_10_01) $display("FAIL sat_boundary: got %b exp 00111001", boundary_bus); else passed++;
    total++; if ({load_done, load_error} !== 2'b11) $display("FAIL sat_flags_done: got %b exp 11", {load_done, load_error}); else passed++;
    global_stage = 3'd0;
    step();
    total++; if ({load_done, load_error} !== 2'b11) $display("FAIL sat_flags_idle: got %b exp 11", {load_done, load_error}); else passed++;
    global_stage = LD;
    step();
    total++; if ({load_done, load_error} !== 2'b00) $display("FAIL sat_flags_reentry: got %b exp 00", {load_done, load_error}); else passed++;
  endtask
  task automatic test_abort();
    in_valid = 1'b1;
    in_data = 4'b11_10;
    step();
    in_data = 4'b01_01;
    step();
    in_valid = 1'b0;
    global_stage = 3'd0;
    step();
    total++; if (in_ready !== 1'b0) $display("FAIL abort_ready: got %b exp 0", in_ready); else passed++;
    total++; if ({load_done, load_error} !== 2'b01) $display("FAIL abort_flags: got %b exp 01", {load_done, load_error}); else passed++;
    total++; if (weight_bus !== 8'b00_01_01_10) $display("FAIL abort_weight: got %b exp 00010110", weight_bus); else passed++;
    total++; if (boundary_bus !== 8'b00_11_01_11) $display("FAIL abort_boundary: got %b exp 00110111", boundary_bus); else passed++;
  endtask
  task automatic test_async_reset();
    global_stage = LD;
    step();
    in_valid = 1'b1;
    in_data = 4'b01_10;
    step();
    total++; if (in_ready !== 1'b1) $display("FAIL areset_pre_ready: got %b exp 1", in_ready); else passed++;
    #3;
    reset = 1'b1;
    #1;
    total++; if (weight_bus !== 8'h00) $display("FAIL areset_weight: got %b exp 00000000", weight_bus); else passed++;
    total++; if (boundary_bus !== 8'h00) $display("FAIL areset_boundary: got %b exp 00000000", boundary_bus); else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL areset_ready: got %b exp 0", in_ready); else passed++;
    total++; if ({load_done, load_error} !== 2'b00) $display("FAIL areset_flags: got %b exp 00", {load_done, load_error}); else passed++;
    in_valid = 1'b0;
    global_stage = 3'd0;
    step();
    reset = 1'b0;
    step();
  endtask
`ifdef LINK_PARAM_CHECKSUM_EN
  task automatic test_checksum();
    logic [3:0] words [4];
    words[0] = 4'b00_01;
    words[1] = 4'b01_10;
    words[2] = 4'b10_00;
    words[3] = 4'b00_10;
    for (int r = 0; r < 2; r++) begin
      global_stage = 3'd0;
      in_valid = 1'b0;
      step();
      global_stage = LD;
      step();
      in_valid = 1'b1;
      for (int w = 0; w < 4; w++) begin
        in_data = words[w];
        step();
      end
      total++; if (load_done !== 1'b0) $display("FAIL csum_done_before_word: got %b exp 0", load_done); else passed++;
      in_data = r == 0 ? 4'b1101 : 4'b0000;
      step();
      in_valid = 1'b0;
      total++; if ({load_done, load_error} !== (r == 0 ? 2'b10 : 2'b11)) $display("FAIL csum_flags_%0d: got %b exp %b", r, {load_done, load_error}, r == 0 ? 2'b10 : 2'b11); else passed++;
    end
  endtask
`endif
  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_saturation();
    test_abort();
    test_async_reset();
`ifdef LINK_PARAM_CHECKSUM_EN
    test_checksum();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
